// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI shift engine between NUM_REQ requesters.
// Define SPI_ARB_TIMEOUT_EN to add the done-wait timeout counter and the ERROR path.
module spi_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TO_W    = 12
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [32*NUM_REQ-1:0]  wdat_i,
  input  logic [2*NUM_REQ-1:0]   sel_i,
  output logic [NUM_REQ-1:0]     ack_o,
  output logic [NUM_REQ-1:0]     err_o,
  output logic [31:0]            rdat_o,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic                   busy_o,
  output logic [31:0]            spi_o,
  output logic [1:0]             spi_sel_o,
  output logic                   spi_start_o,
  input  logic                   spi_done_i,
  input  logic [31:0]            spi_i
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LAUNCH   = 3'd1;
  localparam logic [2:0] SHIFT    = 3'd2;
  localparam logic [2:0] COMPLETE = 3'd3;
  localparam logic [2:0] ERROR    = 3'd4;

  logic [2:0]                    state;
  logic [PW-1:0]                 ptr;
  logic [PW-1:0]                 win;
  logic                          found;
  logic                          to_hit;
  logic [NUM_REQ-1:0][31:0]      wdat_a;
  logic [NUM_REQ-1:0][1:0]       sel_a;

  assign wdat_a = wdat_i;
  assign sel_a  = sel_i;

  // First set request searching upward from ptr+1, wrapping at NUM_REQ.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int k;
      k = (int'(ptr) + i) % NUM_REQ;
      if (!found && req_i[PW'(k)]) begin
        found = 1'b1;
        win   = PW'(k);
      end
    end
  end

  assign busy_o      = (state != IDLE);
  assign spi_start_o = (state == LAUNCH) || (state == SHIFT);
  assign ack_o       = (state == COMPLETE) ? gnt_o : '0;

`ifdef SPI_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  // Fires on the edge that brings the counter to all-ones.
  assign to_hit = (to_cnt == {{(TO_W-1){1'b1}}, 1'b0});
  assign err_o  = (state == ERROR) ? gnt_o : '0;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      to_cnt <= '0;
    else if (state == IDLE)
      to_cnt <= '0;
    else if ((state == LAUNCH || state == SHIFT) && !(&to_cnt))
      to_cnt <= to_cnt + 1'b1;
  end
`else
  assign to_hit = (TO_W < 0);
  assign err_o  = '0;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= IDLE;
      gnt_o     <= '0;
      rdat_o    <= '0;
      spi_o     <= '0;
      spi_sel_o <= '0;
      ptr       <= PW'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: if (found) begin
          gnt_o     <= NUM_REQ'(1) << win;
          spi_o     <= wdat_a[win];
          spi_sel_o <= sel_a[win];
          ptr       <= win;
          state     <= LAUNCH;
        end
        // Done low counts as acceptance even if the engine was already busy.
        LAUNCH: if (!spi_done_i) state <= SHIFT;
                else if (to_hit) state <= ERROR;
        SHIFT: if (spi_done_i) begin
          rdat_o <= spi_i;
          state  <= COMPLETE;
        end else if (to_hit) state <= ERROR;
        COMPLETE, ERROR: begin
          gnt_o <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_arbiter.sv
// Directed vector bench for spi_arbiter with a small behavioural SPI engine.
module tb_spi_arbiter;
  localparam int N  = 4;
  localparam int TW = 4;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [N-1:0]      req_i;
  logic [32*N-1:0]   wdat_i;
  logic [2*N-1:0]    sel_i;
  logic [N-1:0]      ack_o, err_o, gnt_o;
  logic [31:0]       rdat_o, spi_o, spi_i;
  logic              busy_o, spi_start_o, spi_done_i;
  logic [1:0]        spi_sel_o;

  int total = 0;
  int bad   = 0;
  int eng_drop = 2;
  int eng_len  = 8;
  bit eng_hang = 1'b0;
  logic [31:0] eng_rdata = '0;

  spi_arbiter #(.NUM_REQ(N), .TO_W(TW)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .wdat_i(wdat_i), .sel_i(sel_i),
    .ack_o(ack_o), .err_o(err_o), .rdat_o(rdat_o), .gnt_o(gnt_o), .busy_o(busy_o),
    .spi_o(spi_o), .spi_sel_o(spi_sel_o), .spi_start_o(spi_start_o),
    .spi_done_i(spi_done_i), .spi_i(spi_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] wd;
    logic [1:0]  sd;
    logic [31:0] rd;
    logic [3:0]  gnt;
    logic [31:0] spi;
    logic [1:0]  sel;
    bit          chg;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // Engine: drops done eng_drop cycles after start, raises it eng_len cycles later.
  initial begin
    int est;
    int ecnt;
    est = 0; ecnt = 0;
    spi_done_i = 1'b1;
    spi_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      if (reset_i) begin
        est = 0; spi_done_i = 1'b1;
      end else if (est != 0 && !spi_start_o) begin
        est = 0; spi_done_i = 1'b1;
      end else begin
        case (est)
          0: if (spi_start_o) begin ecnt = eng_drop - 1; est = 1; end
          1: if (ecnt == 0) begin spi_done_i = 1'b0; ecnt = eng_len - 1; est = 2; end
             else ecnt--;
          2: if (!eng_hang) begin
               if (ecnt == 0) begin spi_done_i = 1'b1; spi_i = eng_rdata; est = 3; end
               else ecnt--;
             end
          default: ;
        endcase
      end
    end
  end

  task automatic run_txn(input vec_t v);
    int k;
    req_i = v.req;
    eng_rdata = v.rd;
    for (int n = 0; n < N; n++) begin
      wdat_i[32*n +: 32] = v.wd + 32'(n);
      sel_i[2*n +: 2]    = v.sd + 2'(n);
    end
    k = 0;
    do begin @(negedge clk_i); k++; end while (gnt_o == '0 && k < 10);
    if (gnt_o == '0) timeout_fail("grant_wait");
    chk("gnt", 32'(gnt_o), 32'(v.gnt));
    chk("spi_o", spi_o, v.spi);
    chk("spi_sel", 32'(spi_sel_o), 32'(v.sel));
    chk("start_on_grant", 32'(spi_start_o), 32'd1);
    chk("busy", 32'(busy_o), 32'd1);
    if (v.chg) begin
      k = 0;
      while (spi_done_i && k < 20) begin @(negedge clk_i); k++; end
      if (spi_done_i) timeout_fail("shift_wait");
      wdat_i = '1;
      sel_i  = '0;
      @(negedge clk_i);
      chk("spi_o_hold", spi_o, v.spi);
    end
    k = 0;
    while (ack_o == '0 && k < 50) begin @(negedge clk_i); k++; end
    if (ack_o == '0) timeout_fail("ack_wait");
    chk("ack", 32'(ack_o), 32'(v.gnt));
    chk("err_quiet", 32'(err_o), 32'd0);
    chk("rdat", rdat_o, v.rd);
    chk("spi_o_at_ack", spi_o, v.spi);
    chk("spi_sel_at_ack", 32'(spi_sel_o), 32'(v.sel));
    chk("start_dropped", 32'(spi_start_o), 32'd0);
    @(negedge clk_i);
    chk("ack_width", 32'(ack_o), 32'd0);
    chk("gnt_cleared", 32'(gnt_o), 32'd0);
    chk("idle_gap", 32'(busy_o), 32'd0);
  endtask

  initial begin
    vec_t vr;
    int k;
    logic [31:0] rd_before;
    // req, wd, sd, rd, exp gnt, exp spi_o, exp sel, change-after-grant
    vt[0]  = '{4'b1111, 32'h1000_0000, 2'd0, 32'h1111_0000, 4'b0001, 32'h1000_0000, 2'b00, 1'b0};
    vt[1]  = '{4'b1111, 32'h2000_0000, 2'd1, 32'h2222_0000, 4'b0010, 32'h2000_0001, 2'b10, 1'b0};
    vt[2]  = '{4'b1111, 32'h3000_0000, 2'd0, 32'h3333_0000, 4'b0100, 32'h3000_0002, 2'b10, 1'b0};
    vt[3]  = '{4'b1111, 32'h4000_0000, 2'd0, 32'h4444_0000, 4'b1000, 32'h4000_0003, 2'b11, 1'b0};
    vt[4]  = '{4'b1111, 32'h5000_0000, 2'd3, 32'h5555_0000, 4'b0001, 32'h5000_0000, 2'b11, 1'b0};
    vt[5]  = '{4'b0001, 32'hA5A5_0F0F, 2'd2, 32'h1234_5678, 4'b0001, 32'hA5A5_0F0F, 2'b10, 1'b0};
    vt[6]  = '{4'b0100, 32'h6000_0000, 2'd0, 32'h6666_0000, 4'b0100, 32'h6000_0002, 2'b10, 1'b0};
    vt[7]  = '{4'b0101, 32'h7000_0000, 2'd0, 32'h7777_0000, 4'b0001, 32'h7000_0000, 2'b00, 1'b0};
    vt[8]  = '{4'b0101, 32'h8000_0000, 2'd1, 32'h8888_0000, 4'b0100, 32'h8000_0002, 2'b11, 1'b0};
    vt[9]  = '{4'b1010, 32'h9000_0000, 2'd2, 32'h9999_0000, 4'b1000, 32'h9000_0003, 2'b01, 1'b0};
    vt[10] = '{4'b0010, 32'hABCD_0000, 2'd3, 32'hCAFE_F00D, 4'b0010, 32'hABCD_0001, 2'b00, 1'b1};

    reset_i = 1'b1;
    req_i = '0; wdat_i = '0; sel_i = '0;
    @(negedge clk_i); @(negedge clk_i);
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_rdat", rdat_o, 32'd0);
    chk("rst_spi_o", spi_o, 32'd0);
    chk("rst_sel", 32'(spi_sel_o), 32'd0);
    chk("rst_start", 32'(spi_start_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    reset_i = 1'b0;

    for (int i = 0; i < 11; i++) run_txn(vt[i]);

    // Asynchronous reset in the middle of a shift.
    req_i = 4'b0100;
    eng_rdata = 32'hDEAD_BEEF;
    k = 0;
    do begin @(negedge clk_i); k++; end while (spi_done_i && k < 20);
    if (spi_done_i) timeout_fail("rst_shift_wait");
    chk("pre_rst_gnt", 32'(gnt_o), 32'b0100);
    #2 reset_i = 1'b1;
    #1;
    chk("arst_start", 32'(spi_start_o), 32'd0);
    chk("arst_gnt", 32'(gnt_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_rdat", rdat_o, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("arst_no_ack", 32'(ack_o | err_o), 32'd0);
    end
    reset_i = 1'b0;
    vr = '{4'b1111, 32'hB000_0000, 2'd1, 32'h0BAD_F00D, 4'b0001, 32'hB000_0000, 2'b01, 1'b0};
    run_txn(vr);

`ifdef SPI_ARB_TIMEOUT_EN
    // Engine accepts but never finishes; err fires 15 cycles after LAUNCH entry.
    eng_hang = 1'b1;
    rd_before = rdat_o;
    req_i = 4'b0010;
    @(negedge clk_i);
    chk("to_gnt", 32'(gnt_o), 32'b0010);
    k = 0;
    while (err_o == '0 && k < 40) begin @(negedge clk_i); k++; end
    if (err_o == '0) timeout_fail("err_wait");
    chk("to_cycles", 32'(k), 32'd15);
    chk("to_err", 32'(err_o), 32'b0010);
    chk("to_no_ack", 32'(ack_o), 32'd0);
    chk("to_start", 32'(spi_start_o), 32'd0);
    chk("to_rdat", rdat_o, rd_before);
    req_i = '0;
    @(negedge clk_i);
    chk("to_busy", 32'(busy_o), 32'd0);
    chk("to_err_width", 32'(err_o), 32'd0);
    eng_hang = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
